// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

    // Default geometry: 4 registers of 8 bits.
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned NREG_DEF   = 4;

    // Requester indices, also the encoding of last_grant.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // One writeback request at the default geometry.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] dest;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_wr_slot.sv
// One-entry holding register for a writeback requester.
// A load in the same cycle as a drain refills the slot, so it stays full.
module regfile_wr_arbiter_wr_slot
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_data,
    output logic              full,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] data
);

    // Slot contents and occupancy; load wins over drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            dest <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            dest <= in_dest;
            data <= in_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between an ALU (A) and a load (B) requester.
// Round-robin arbitration, with oldest-first ordering when both slots target the
// same register so the younger write lands last.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned NREG        = NREG_DEF,
    parameter bit          TIE_A_OLDER = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteR,
    output logic [DATA_W-1:0] WriteD,
    output logic [NREG-1:0]   pending,
    output logic              last_grant
);

    logic              a_full;
    logic              b_full;
    logic [ADDR_W-1:0] a_dest;
    logic [ADDR_W-1:0] b_dest;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] b_wdata;
    logic              a_load;
    logic              b_load;
    logic              grant_a;
    logic              grant_b;
    logic              grant_any;
    // 1 = slot B holds the older entry; only meaningful while both slots are full.
    logic              older_b;

    regfile_wr_arbiter_wr_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_slot_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (a_load),
        .drain   (grant_a),
        .in_dest (a_reg),
        .in_data (a_data),
        .full    (a_full),
        .dest    (a_dest),
        .data    (a_wdata)
    );

    regfile_wr_arbiter_wr_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_slot_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (b_load),
        .drain   (grant_b),
        .in_dest (b_reg),
        .in_data (b_data),
        .full    (b_full),
        .dest    (b_dest),
        .data    (b_wdata)
    );

    // Arbitration: single full slot wins; contention resolved by age or round-robin.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_full && b_full) begin
            if (a_dest == b_dest) begin
                grant_b = older_b;
            end else begin
                grant_b = (last_grant == REQ_A);
            end
            grant_a = !grant_b;
        end else begin
            grant_a = a_full;
            grant_b = b_full;
        end
    end

    assign grant_any = grant_a | grant_b;

    // Ready depends only on slot state and grant, and is held low during reset.
    assign a_ready = rst_n & (!a_full | grant_a);
    assign b_ready = rst_n & (!b_full | grant_b);
    assign a_load  = a_valid & a_ready;
    assign b_load  = b_valid & b_ready;

    // Age tracking: an entry loaded beside a slot that stays full is the younger one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            older_b <= 1'b0;
        end else if (a_load && b_load) begin
            older_b <= !TIE_A_OLDER;
        end else if (a_load && b_full && !grant_b) begin
            older_b <= 1'b1;
        end else if (b_load && a_full && !grant_a) begin
            older_b <= 1'b0;
        end
    end

    // Registered write stage; index and data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWrite   <= 1'b0;
            WriteR     <= '0;
            WriteD     <= '0;
            last_grant <= REQ_B;
        end else begin
            RegWrite <= grant_any;
            if (grant_any) begin
                WriteR     <= grant_b ? b_dest : a_dest;
                WriteD     <= grant_b ? b_wdata : a_wdata;
                last_grant <= grant_b ? REQ_B : REQ_A;
            end
        end
    end

    // Pending mask: every register with a write held in a slot or the write stage.
    always_comb begin
        pending = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if ((a_full && (a_dest == ADDR_W'(r))) ||
                (b_full && (b_dest == ADDR_W'(r))) ||
                (RegWrite && (WriteR == ADDR_W'(r)))) begin
                pending[r] = 1'b1;
            end
        end
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port (RegWrite/WriteR/WriteD) between two writeback requesters: A = ALU result, B = load/memory result.
- Each requester has a valid/ready handshake into a one-entry holding slot.
- A round-robin arbiter with same-destination ordering protection drains the slots into a registered write stage.
- Exports a per-register pending mask that the decode/hazard logic uses to stall reads of registers with in-flight writes.

Parameters:
- DATA_W, 8, width of write data (matches register file word).
- ADDR_W, 2, register index width.
- NREG, 4, number of registers; must equal 2**ADDR_W.
- TIE_A_OLDER, 1, ordering when A and B are accepted on the same edge: 1 = A treated as older, 0 = B treated as older.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- a_valid  in  1  requester A presents a write.
- a_ready  out  1  slot A can accept this cycle.
- a_reg  in  ADDR_W  destination register for A.
- a_data  in  DATA_W  write data for A.
- b_valid  in  1  requester B presents a write.
- b_ready  out  1  slot B can accept this cycle.
- b_reg  in  ADDR_W  destination register for B.
- b_data  in  DATA_W  write data for B.
- RegWrite  out  1  write enable to register file (registered).
- WriteR  out  ADDR_W  write index to register file (registered).
- WriteD  out  DATA_W  write data to register file (registered).
- pending  out  NREG  bit r = 1 while any write to register r is held in a slot or in the write stage.
- last_grant  out  1  0 = A won the most recent grant, 1 = B won (registered).

Behaviour:
- Reset, when rst_n = 0 at a clock edge:
  - both slots empty; RegWrite = 0, WriteR = 0, WriteD = 0; last_grant = 1, so A wins the first contested grant; age bit cleared.
  - While in reset, a_ready = b_ready = 0.
  - Reset mid-operation discards held slot contents and any staged write; no RegWrite pulse in the cycle after reset.
- Accept: transfer on X_valid & X_ready at a rising edge. X_ready = !slotX_full | grantX (same-cycle drain and refill allowed). Combinational only from slot state and grant; no dependence on X_valid.
- Grant, evaluated combinationally each cycle from slot state:
  - no slot full -> no grant.
  - exactly one full -> that slot granted.
  - both full, different destinations -> round-robin: grant the requester not equal to last_grant.
  - both full, same destination -> grant the older entry (age bit), regardless of round-robin; the younger entry drains next cycle, so the final register value is the younger write.
- Age bit:
  - set when a slot is loaded while the other is already full (the loaded entry is younger).
  - on simultaneous load into two empty slots, TIE_A_OLDER decides.
- Write stage, at each edge:
  - RegWrite <= grant_any; on a grant, WriteR/WriteD <= granted slot contents, and last_grant updates.
  - With no grant, WriteR/WriteD hold their previous values and RegWrite = 0.
- Latency:
  - accept at edge N -> earliest RegWrite = 1 in the cycle after edge N+1 -> register file captures at edge N+2.
  - Throughput is one write per cycle total.
- pending: OR of decoded slotA dest (if full), slotB dest (if full), and WriteR (if RegWrite). Purely combinational from registered state.
- No back-pressure from the register file; the write stage always completes in one cycle.
- Invalid inputs while !X_valid are ignored; X_reg/X_data are sampled only on accept.

Decomposition:
- Shared package holds:
  - DATA_W/ADDR_W/NREG defaults.
  - Requester index constants REQ_A = 0, REQ_B = 1.
  - Writeback request struct {reg, data}.
- One natural sub-module: wr_slot, a one-entry holding register with full flag, load, and drain (instantiated twice).
- The arbiter, age bit, write stage and pending decode stay in the top module.

Test Plan:
- Reset: hold rst_n = 0 with a_valid = b_valid = 1 -> a_ready = b_ready = 0, RegWrite = 0, pending = 4'b0000, and no write in the first cycle after rst_n rises.
- Single A write:
  - a_valid for one cycle, a_reg = 2'b00, a_data = 8'hAA -> RegWrite = 1, WriteR = 0, WriteD = 8'hAA exactly one cycle after accept.
  - pending = 4'b0001 from accept through that cycle, then 0.
- Round-robin: A and B both continuously valid, A to r1 = 8'hFF, B to r2 = 8'h11, starting from reset -> grants alternate A, B, A, B; last_grant toggles; a_ready/b_ready each high every other cycle after the slots fill.
- Same-destination ordering: A (r3, 8'hAB) accepted one edge before B (r3, 8'hCD), with last_grant = 0 -> A written first despite round-robin, then B; the register file ends with r3 = 8'hCD and pending[3] drops after the second write.
- Simultaneous accept to the same register with TIE_A_OLDER = 1: A (r0, 8'h01), B (r0, 8'h02) on the same edge -> writes 8'h01 then 8'h02. Repeat with TIE_A_OLDER = 0 -> writes 8'h02 then 8'h01.
- Reset mid-operation: both slots full, pull rst_n = 0 for one edge -> no further RegWrite pulses, pending = 0, both readies return to 1 once rst_n is high.
